// File: rtl/mem_pkg.sv
// Shared types and default widths for the data-memory path.
// The store buffer queues sb_entry_t records between the CPU and the cache.
package mem_pkg;

  localparam int SB_DEPTH      = 4;
  localparam int SB_ADDR_WIDTH = 32;
  localparam int SB_DATA_WIDTH = 32;
  localparam int SB_BE_WIDTH   = SB_DATA_WIDTH / 8;

  typedef struct packed {
    logic [SB_ADDR_WIDTH-1:0] addr;
    logic [SB_BE_WIDTH-1:0]   be;
    logic [SB_DATA_WIDTH-1:0] data;
  } sb_entry_t;

endpackage

// File: rtl/store_buffer_if.sv
// Memory-port bundle with waitrequest handshake, used on both the CPU and the cache side.
// The master drives the request; the slave answers with waitrequest and load data.
interface store_buffer_if
  import mem_pkg::*;
#(
  parameter int ADDR_WIDTH = SB_ADDR_WIDTH,
  parameter int DATA_WIDTH = SB_DATA_WIDTH
);

  logic [ADDR_WIDTH-1:0]   addr;
  logic                    rd;
  logic                    wr;
  logic [DATA_WIDTH/8-1:0] wr_be;
  logic [DATA_WIDTH-1:0]   wr_data;
  logic [DATA_WIDTH-1:0]   rd_data;
  logic                    waitrequest;

  modport master (output addr, rd, wr, wr_be, wr_data, input rd_data, waitrequest);
  modport slave  (input addr, rd, wr, wr_be, wr_data, output rd_data, waitrequest);

endinterface

// File: rtl/sb_fifo.sv
// Synchronous FIFO of store entries with a combinational head read.
// Push while full and pop while empty are ignored.
module sb_fifo
  import mem_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          push,
  input  sb_entry_t     push_entry,
  input  logic          pop,
  output sb_entry_t     head_entry,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  sb_entry_t     entry_reg [DEPTH];
  logic [PW-1:0] head_reg;
  logic [PW-1:0] tail_reg;
  logic [CW-1:0] count_reg;
  logic          do_push;
  logic          do_pop;

  assign full    = (count_reg == CW'(DEPTH));
  assign empty   = (count_reg == '0);
  assign count   = count_reg;
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Slot storage carries no reset; only the pointers and count define validity.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
    always_ff @(posedge clock) begin
      if (do_push && tail_reg == PW'(gi)) begin
        entry_reg[gi] <= push_entry;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      if (do_push) tail_reg <= tail_reg + PW'(1);
      if (do_pop)  head_reg <= head_reg + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign head_entry = entry_reg[head_reg];

endmodule

// File: rtl/store_buffer.sv
// Posted-write buffer: stores are accepted immediately while a slot is free and drain
// to the cache in order; loads wait until the buffer is empty, then pass straight through.
module store_buffer
  import mem_pkg::*;
#(
  parameter int DEPTH      = SB_DEPTH,
  parameter int ADDR_WIDTH = SB_ADDR_WIDTH,
  parameter int DATA_WIDTH = SB_DATA_WIDTH,
  localparam int CW        = $clog2(DEPTH + 1)
) (
  input  logic          clock,
  input  logic          reset_n,
  store_buffer_if.slave  cpu,
  store_buffer_if.master cache
);

  sb_entry_t               push_entry;
  sb_entry_t               head_entry;
  logic                    full;
  logic                    empty;
  logic [CW-1:0]           count;
  logic                    push;
  logic                    pop;
  logic [ADDR_WIDTH-1:0]   head_addr;
  logic [DATA_WIDTH/8-1:0] head_be;
  logic [DATA_WIDTH-1:0]   head_data;

  logic [31:0] stat_stores;
  logic [31:0] stat_full_stalls;
  logic [31:0] stat_load_stalls;

  // A simultaneous load wins; the store half of an illegal rd+wr is dropped.
  assign push = cpu.wr & ~cpu.rd & ~full;
  assign pop  = ~empty & ~cache.waitrequest;

  assign push_entry.addr = cpu.addr;
  assign push_entry.be   = cpu.wr_be;
  assign push_entry.data = cpu.wr_data;

  assign head_addr = head_entry.addr;
  assign head_be   = head_entry.be;
  assign head_data = head_entry.data;

  sb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock      (clock),
    .reset_n    (reset_n),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .head_entry (head_entry),
    .full       (full),
    .empty      (empty),
    .count      (count)
  );

  assign cpu.rd_data = cache.rd_data;

  always_comb begin
    cache.addr      = cpu.addr;
    cache.rd        = 1'b0;
    cache.wr        = 1'b0;
    cache.wr_be     = '0;
    cache.wr_data   = '0;
    cpu.waitrequest = 1'b0;
    if (!empty) begin
      cache.wr        = 1'b1;
      cache.addr      = head_addr;
      cache.wr_be     = head_be;
      cache.wr_data   = head_data;
      cpu.waitrequest = cpu.rd | (cpu.wr & full);
    end else if (cpu.rd) begin
      cache.rd        = 1'b1;
      cpu.waitrequest = cache.waitrequest;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stat_stores      <= '0;
      stat_full_stalls <= '0;
      stat_load_stalls <= '0;
    end else begin
      if (push)             stat_stores      <= stat_stores + 32'd1;
      if (cpu.wr && full)   stat_full_stalls <= stat_full_stalls + 32'd1;
      if (cpu.rd && !empty) stat_load_stalls <= stat_load_stalls + 32'd1;
    end
  end

endmodule
